// File: rtl/inst_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package inst_fetch_pkg;

  localparam int unsigned INST_W      = 32;
  localparam int unsigned ADDR_W_DEF  = 32;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef logic [INST_W-1:0] inst_t;

  function automatic logic misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// ROM bus plus IF/ID handshake between fetch (master) and ROM/decode (slave).
interface inst_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  import inst_fetch_pkg::*;

  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  inst_t             rom_data;
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  inst_t             id_inst;
  logic              id_adel;
  logic              br_e;
  logic [ADDR_W-1:0] br_target;

  modport master (
    output rom_ce, rom_addr, id_valid, id_pc, id_inst, id_adel,
    input  rom_data, id_ready, br_e, br_target
  );

  modport slave (
    input  rom_ce, rom_addr, id_valid, id_pc, id_inst, id_adel,
    output rom_data, id_ready, br_e, br_target
  );

endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Program counter, pending-redirect holder for branches accepted while frozen,
// and ROM chip enable.
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_advance,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_br_target,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_rom_ce
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_rom_ce;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_target;
  logic [ADDR_W-1:0] w_next_pc;

  // A redirect seen this cycle beats an older pending one (latest wins).
  always_comb begin
    w_next_pc = r_pc + ADDR_W'(4);
    if (i_redirect) begin
      w_next_pc = i_br_target;
    end else if (r_pend_valid) begin
      w_next_pc = r_pend_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_rom_ce      <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_rom_ce <= 1'b1;
      if (i_advance) begin
        r_pc         <= w_next_pc;
        r_pend_valid <= 1'b0;
      end else if (i_redirect) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= i_br_target;
      end
    end
  end

  assign o_pc     = r_pc;
  assign o_rom_ce = r_rom_ce;

endmodule

// File: rtl/inst_fetch.sv
// IF stage: drives the ROM from the PC and captures the returned word into
// the IF/ID register, handed to decode over valid/ready with one delay slot.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF[ADDR_W-1:0]
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  inst_fetch_if.master bus
);

  logic [ADDR_W-1:0] w_pc;
  logic              w_rom_ce;
  logic              w_consume;
  logic              w_advance;
  logic              w_redirect;

  logic              r_id_valid;
  logic [ADDR_W-1:0] r_id_pc;
  inst_t             r_id_inst;
  logic              r_id_adel;

  assign w_consume  = r_id_valid & bus.id_ready;
  assign w_advance  = w_rom_ce & i_en & (~r_id_valid | bus.id_ready);
  assign w_redirect = w_consume & bus.br_e;

  inst_fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .i_advance   (w_advance),
    .i_redirect  (w_redirect),
    .i_br_target (bus.br_target),
    .o_pc        (w_pc),
    .o_rom_ce    (w_rom_ce)
  );

  // The word fetched alongside a consumed branch is its delay slot and always lands here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= '0;
      r_id_inst  <= ZERO_WORD;
      r_id_adel  <= 1'b0;
    end else if (w_advance) begin
      r_id_valid <= 1'b1;
      r_id_pc    <= w_pc;
      r_id_inst  <= bus.rom_data;
      r_id_adel  <= misaligned(w_pc[1:0]);
    end else if (w_consume) begin
      r_id_valid <= 1'b0;
    end
  end

  assign bus.rom_ce   = w_rom_ce;
  assign bus.rom_addr = w_pc;
  assign bus.id_valid = r_id_valid;
  assign bus.id_pc    = r_id_pc;
  assign bus.id_inst  = r_id_inst;
  assign bus.id_adel  = r_id_adel;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch driving an 8-word combinational ROM.
module tb_inst_fetch;

  logic clk;
  logic rst;
  logic i_en;
  int   n_checks;
  int   n_errors;

  inst_fetch_if #(.ADDR_W(32)) bus ();

  inst_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .rst  (rst),
    .i_en (i_en),
    .bus  (bus)
  );

  function automatic logic [31:0] rom_word(input logic [2:0] idx);
    case (idx)
      3'd0: return 32'h3C01_0001;
      3'd1: return 32'h3421_0010;
      3'd2: return 32'h2022_0004;
      3'd3: return 32'h0041_1820;
      3'd4: return 32'hAC03_0000;
      3'd5: return 32'h8C04_0000;
      3'd6: return 32'h1000_FFF9;
      default: return 32'h2084_0001;
    endcase
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr[4:2]);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_start();
    rst = 1'b1; i_en = 1'b0; bus.id_ready = 1'b0; bus.br_e = 1'b0; bus.br_target = '0;
    step();
    rst = 1'b0; i_en = 1'b1; bus.id_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_en = 1'b0; bus.id_ready = 1'b0; bus.br_e = 1'b0; bus.br_target = '0;
    step();
    n_checks++;
    if ({bus.rom_ce, bus.id_valid, bus.id_adel} !== 3'b000 || bus.id_pc !== 32'h0 ||
        bus.id_inst !== 32'h0 || bus.rom_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_state: ce=%b v=%b adel=%b pc=%h inst=%h addr=%h, want all zero",
               bus.rom_ce, bus.id_valid, bus.id_adel, bus.id_pc, bus.id_inst, bus.rom_addr);
    end
    rst = 1'b0; i_en = 1'b1; bus.id_ready = 1'b1;
    step();
    n_checks++;
    if (bus.rom_ce !== 1'b1 || bus.id_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL first_edge: ce=%b v=%b, want ce=1 v=0", bus.rom_ce, bus.id_valid);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4 * i) ||
          bus.id_inst !== rom_word(3'(i)) || bus.id_adel !== 1'b0) begin
        n_errors++;
        $display("FAIL stream_%0d: v=%b pc=%h inst=%h adel=%b, want v=1 pc=%h inst=%h adel=0",
                 i, bus.id_valid, bus.id_pc, bus.id_inst, bus.id_adel, 32'(4 * i), rom_word(3'(i)));
      end
    end
  endtask

  task automatic test_stall();
    reset_start();
    step();
    step();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8 || bus.id_inst !== 32'h2022_0004 ||
          bus.rom_addr !== 32'hC) begin
        n_errors++;
        $display("FAIL stall_hold_%0d: v=%b pc=%h inst=%h addr=%h, want v=1 pc=8 inst=20220004 addr=c",
                 i, bus.id_valid, bus.id_pc, bus.id_inst, bus.rom_addr);
      end
    end
    bus.id_ready = 1'b1;
    step();
    n_checks++;
    if (bus.id_pc !== 32'hC || bus.id_inst !== 32'h0041_1820) begin
      n_errors++;
      $display("FAIL stall_release: pc=%h inst=%h, want pc=c inst=00411820", bus.id_pc, bus.id_inst);
    end
    step();
    n_checks++;
    if (bus.id_pc !== 32'h10) begin
      n_errors++;
      $display("FAIL stall_next: pc=%h, want 10", bus.id_pc);
    end
  endtask

  task automatic test_branch();
    reset_start();
    for (int i = 0; i < 7; i++) step();
    n_checks++;
    if (bus.id_pc !== 32'h1C) begin
      n_errors++;
      $display("FAIL branch_setup: pc=%h, want 1c", bus.id_pc);
    end
    bus.br_e = 1'b1; bus.br_target = 32'h4;
    step();
    bus.br_e = 1'b0;
    n_checks++;
    if (bus.id_pc !== 32'h20 || bus.id_inst !== 32'h3C01_0001 || bus.rom_addr !== 32'h4) begin
      n_errors++;
      $display("FAIL branch_delay_slot: pc=%h inst=%h addr=%h, want pc=20 inst=3c010001 addr=4",
               bus.id_pc, bus.id_inst, bus.rom_addr);
    end
    step();
    n_checks++;
    if (bus.id_pc !== 32'h4 || bus.id_inst !== 32'h3421_0010) begin
      n_errors++;
      $display("FAIL branch_target: pc=%h inst=%h, want pc=4 inst=34210010", bus.id_pc, bus.id_inst);
    end
    step();
    n_checks++;
    if (bus.id_pc !== 32'h8) begin
      n_errors++;
      $display("FAIL branch_after: pc=%h, want 8", bus.id_pc);
    end
  endtask

  task automatic test_branch_frozen();
    reset_start();
    step();
    i_en = 1'b0; bus.br_e = 1'b1; bus.br_target = 32'h10;
    step();
    bus.br_e = 1'b0;
    n_checks++;
    if (bus.id_valid !== 1'b0 || bus.rom_addr !== 32'h8) begin
      n_errors++;
      $display("FAIL frozen_consume: v=%b addr=%h, want v=0 addr=8", bus.id_valid, bus.rom_addr);
    end
    step();
    n_checks++;
    if (bus.id_valid !== 1'b0 || bus.rom_addr !== 32'h8) begin
      n_errors++;
      $display("FAIL frozen_hold: v=%b addr=%h, want v=0 addr=8", bus.id_valid, bus.rom_addr);
    end
    i_en = 1'b1;
    step();
    n_checks++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h8 || bus.rom_addr !== 32'h10) begin
      n_errors++;
      $display("FAIL frozen_delay_slot: v=%b pc=%h addr=%h, want v=1 pc=8 addr=10",
               bus.id_valid, bus.id_pc, bus.rom_addr);
    end
    step();
    n_checks++;
    if (bus.id_pc !== 32'h10 || bus.id_inst !== 32'hAC03_0000) begin
      n_errors++;
      $display("FAIL frozen_target: pc=%h inst=%h, want pc=10 inst=ac030000", bus.id_pc, bus.id_inst);
    end
    step();
    n_checks++;
    if (bus.id_pc !== 32'h14) begin
      n_errors++;
      $display("FAIL frozen_after: pc=%h, want 14 (pending must clear)", bus.id_pc);
    end
  endtask

  task automatic test_misaligned();
    reset_start();
    bus.br_e = 1'b1; bus.br_target = 32'h6;
    step();
    bus.br_e = 1'b0;
    n_checks++;
    if (bus.id_pc !== 32'h4 || bus.id_adel !== 1'b0) begin
      n_errors++;
      $display("FAIL adel_delay_slot: pc=%h adel=%b, want pc=4 adel=0", bus.id_pc, bus.id_adel);
    end
    step();
    n_checks++;
    if (bus.id_pc !== 32'h6 || bus.id_adel !== 1'b1 || bus.id_inst !== 32'h3421_0010 ||
        bus.rom_addr !== 32'hA) begin
      n_errors++;
      $display("FAIL adel_target: pc=%h adel=%b inst=%h addr=%h, want pc=6 adel=1 inst=34210010 addr=a",
               bus.id_pc, bus.id_adel, bus.id_inst, bus.rom_addr);
    end
    step();
    n_checks++;
    if (bus.id_pc !== 32'hA || bus.id_adel !== 1'b1 || bus.id_inst !== 32'h2022_0004) begin
      n_errors++;
      $display("FAIL adel_next: pc=%h adel=%b inst=%h, want pc=a adel=1 inst=20220004",
               bus.id_pc, bus.id_adel, bus.id_inst);
    end
  endtask

  task automatic test_wrap();
    reset_start();
    bus.br_e = 1'b1; bus.br_target = 32'hFFFF_FFFC;
    step();
    bus.br_e = 1'b0;
    step();
    n_checks++;
    if (bus.id_pc !== 32'hFFFF_FFFC || bus.id_inst !== 32'h2084_0001) begin
      n_errors++;
      $display("FAIL wrap_top: pc=%h inst=%h, want pc=fffffffc inst=20840001", bus.id_pc, bus.id_inst);
    end
    step();
    n_checks++;
    if (bus.id_pc !== 32'h0 || bus.id_inst !== 32'h3C01_0001) begin
      n_errors++;
      $display("FAIL wrap_zero: pc=%h inst=%h, want pc=0 inst=3c010001", bus.id_pc, bus.id_inst);
    end
  endtask

  task automatic test_async_reset();
    reset_start();
    step();
    bus.id_ready = 1'b0;
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.rom_ce, bus.id_valid, bus.id_adel} !== 3'b000 || bus.id_pc !== 32'h0 ||
        bus.id_inst !== 32'h0 || bus.rom_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL async_reset: ce=%b v=%b adel=%b pc=%h inst=%h addr=%h, want all zero",
               bus.rom_ce, bus.id_valid, bus.id_adel, bus.id_pc, bus.id_inst, bus.rom_addr);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (bus.rom_ce !== 1'b1 || bus.id_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL async_restart_ce: ce=%b v=%b, want ce=1 v=0", bus.rom_ce, bus.id_valid);
    end
    bus.id_ready = 1'b1;
    step();
    n_checks++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h3C01_0001) begin
      n_errors++;
      $display("FAIL async_restart_fetch: v=%b pc=%h inst=%h, want v=1 pc=0 inst=3c010001",
               bus.id_valid, bus.id_pc, bus.id_inst);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    i_en = 1'b0;
    bus.id_ready = 1'b0;
    bus.br_e = 1'b0;
    bus.br_target = '0;
    test_reset();
    test_stall();
    test_branch();
    test_branch_frozen();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
